regfile_wb_ctrl: RTL
====================

Name: regfile_wb_ctrl

Overview:
- Producer side of the register-file write port.
- Accepts writeback requests from the ALU and load unit over valid/ready and buffers them in a small FIFO.
- Drains the FIFO into the edge-sensitive register-file write strobe, one write at a time.
- Keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, writeback FIFO entries; power of 2, ≥2.
- XLEN, 32, data width.
- CNT_W, 2, width of each per-register pending counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- ld_valid  in  1  load writeback request.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load data.
- ld_ready  out  1  load request accepted this cycle.
- issue_valid  in  1  decode issues an instruction writing issue_rd.
- issue_rd  in  5  destination of the issuing instruction.
- issue_ready  out  1  scoreboard can record the issue.
- rs1, rs2  in  5 each  source registers queried by decode.
- rs1_busy, rs2_busy  out  1 each  source has a pending write.
- rf_we  out  1  register-file write strobe (edge-sensitive at the sink).
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- wb_idle  out  1  FIFO empty, FSM in IDLE and all counters zero.

Behaviour:
- Reset (async): FIFO empty; all pending counters 0; FSM to IDLE; round-robin pointer favours ALU.
  - Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, alu_ready=0, ld_ready=0, issue_ready=0, wb_idle=1.
  - Reset mid-write: rf_we drops immediately; the in-flight entry is discarded.
- Arbitration:
  - At most one request is accepted per cycle, and only when the FIFO is not full.
  - Both valid: grant the source not granted last time (round-robin); pointer updates only on an accepted handshake.
  - Single valid: grant it.
  - Ready outputs are combinational from the valids, the full flag and the pointer. A handshake is valid&ready at a rising edge.
  - FIFO full: both readys are 0.
- rd==0 requests:
  - Handshake completes, but nothing is enqueued and the counter is not touched.
  - A FIFO slot is not required: ready is 1 even when full, provided that source holds the grant.
- Drain FSM, three states:
  - IDLE: rf_we=0. If FIFO non-empty → SETUP.
  - SETUP: on entry, pop the head into the rf_waddr/rf_wdata registers; rf_we=0. Next state is STROBE.
  - STROBE: rf_we=1 for exactly one cycle; addr/data held. Next state is SETUP if the FIFO is non-empty at that edge, else IDLE.
  - rf_waddr/rf_wdata are stable for one full cycle before rf_we rises and while it is high, and are held after the strobe until the next pop.
  - rf_we is low for ≥1 cycle between strobes. Peak throughput is one write per 2 cycles.
- Latency: with the FIFO empty and the FSM in IDLE, a handshake at edge k gives IDLE→SETUP at edge k+1 and rf_we high during cycle k+2.
- FIFO ordering: strict acceptance order. Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full when the pointer MSBs differ and the rest are equal; empty when the pointers are equal.
  - Simultaneous push and pop at full is not allowed (ready is 0 while full).
  - Simultaneous push and pop at any other level keeps the count unchanged.
- Scoreboard:
  - cnt[r] increments on issue_valid & issue_ready with issue_rd≠0.
  - cnt[r] decrements at the edge the FSM leaves STROBE, for rf_waddr.
  - Increment and decrement on the same register at the same edge: net unchanged.
  - issue_ready = (issue_rd==0) | (cnt[issue_rd] != 2^CNT_W−1); saturation blocks the issue.
  - rsN_busy = (rsN≠0) & (cnt[rsN]≠0), combinational. Register 0 is never busy.
- Writebacks without a prior issue are legal but must not underflow: a decrement at 0 holds 0.

Test Plan:
- Reset then idle → rf_we=0, rf_waddr=0, wb_idle=1, rs1_busy=0 with rs1=5.
- Issue rd=5; ALU valid rd=5 data=0xDEADBEEF one cycle after → rs1_busy=1 with rs1=5; rf_we pulses once 2 cycles after the handshake with addr=5, data=0xDEADBEEF; rs1_busy=0 the cycle after the strobe.
- ALU and load valid every cycle, rd=1..8, FIFO DEPTH=4 → grants alternate ALU/load; readys drop when full; strobes separated by ≥1 low cycle; write order equals acceptance order.
- Issue rd=3 three times (CNT_W=2), then a fourth → issue_ready=0 on the fourth; after one rd=3 write completes, issue_ready=1.
- ALU valid rd=0 data=0x1234 → alu_ready=1, no rf_we pulse, all counters unchanged.
- Assert rst while rf_we=1 with 2 FIFO entries → rf_we drops asynchronously; FIFO empty; all busies 0; no further strobes after release.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/load writebacks into a FIFO,
// drains them through a SETUP/STROBE write sequence, and tracks pending writes per register.
module regfile_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_idle
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t          state;
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [4:0]      mem_rd   [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic            full;
    logic            empty;
    logic            prefer_ld;
    logic            grant_alu;
    logic            grant_ld;
    logic            alu_fire;
    logic            ld_fire;
    logic            push;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;
    logic            issue_fire;
    logic            any_pending;
    logic [CNT_W-1:0] cnt [32];

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    // Round-robin only matters when both sources request; a lone requester always wins.
    assign grant_alu = alu_valid && (!ld_valid || !prefer_ld);
    assign grant_ld  = ld_valid && (!alu_valid || prefer_ld);

    // rd==0 writes are dropped, so they never need a free FIFO slot.
    assign alu_ready = !rst && grant_alu && (!full || (alu_rd == 5'd0));
    assign ld_ready  = !rst && grant_ld && (!full || (ld_rd == 5'd0));

    assign alu_fire  = alu_valid && alu_ready;
    assign ld_fire   = ld_valid && ld_ready;
    assign push      = (alu_fire && (alu_rd != 5'd0)) || (ld_fire && (ld_rd != 5'd0));
    assign push_rd   = alu_fire ? alu_rd : ld_rd;
    assign push_data = alu_fire ? alu_data : ld_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_ld <= 1'b0;
            wptr      <= '0;
        end else begin
            if (alu_fire) begin
                prefer_ld <= 1'b1;
            end else if (ld_fire) begin
                prefer_ld <= 1'b0;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wptr[AW-1:0]]   <= push_rd;
            mem_data[wptr[AW-1:0]] <= push_data;
        end
    end

    // The head is popped on every transition into SETUP so address/data settle a cycle before the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rptr     <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rf_we <= 1'b0;
                    if (!empty) begin
                        state    <= SETUP;
                        rf_waddr <= mem_rd[rptr[AW-1:0]];
                        rf_wdata <= mem_data[rptr[AW-1:0]];
                        rptr     <= rptr + 1'b1;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    rf_we <= 1'b1;
                end
                STROBE: begin
                    rf_we <= 1'b0;
                    if (!empty) begin
                        state    <= SETUP;
                        rf_waddr <= mem_rd[rptr[AW-1:0]];
                        rf_wdata <= mem_data[rptr[AW-1:0]];
                        rptr     <= rptr + 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

    assign issue_fire = issue_valid && issue_ready;

    // A retiring write and a new issue to the same register cancel out; counters never wrap either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (issue_fire && (issue_rd == 5'(r)) &&
                    !((state == STROBE) && (rf_waddr == 5'(r)))) begin
                    if (cnt[r] != '1) begin
                        cnt[r] <= cnt[r] + 1'b1;
                    end
                end else if ((state == STROBE) && (rf_waddr == 5'(r)) &&
                             !(issue_fire && (issue_rd == 5'(r)))) begin
                    if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - 1'b1;
                    end
                end
            end
        end
    end

    assign issue_ready = !rst && ((issue_rd == 5'd0) || (cnt[issue_rd] != '1));
    assign rs1_busy    = (rs1 != 5'd0) && (cnt[rs1] != '0);
    assign rs2_busy    = (rs2 != 5'd0) && (cnt[rs2] != '0);

    always_comb begin
        any_pending = 1'b0;
        for (int r = 1; r < 32; r++) begin
            if (cnt[r] != '0) begin
                any_pending = 1'b1;
            end
        end
    end

    assign wb_idle = empty && (state == IDLE) && !any_pending;

endmodule
